// File: rtl/sys_cmd_ctrl.sv
// UART command-protocol responder: decodes host frames (RF write/read, ALU with/without
// operands), drives the RegFile and ALU, and queues result bytes into the TX FIFO.
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]     Address,
    output logic                      WrEn,
    output logic                      RdEn,
    output logic [DATA_WIDTH-1:0]     WrData,
    input  logic [DATA_WIDTH-1:0]     RdData,
    input  logic                      RdData_Valid,
    output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
    output logic                      ALU_EN,
    output logic                      CLK_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_Valid,
    output logic [DATA_WIDTH-1:0]     WR_DATA,
    output logic                      WR_INC,
    input  logic                      FIFO_FULL
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA_ST = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8,
        SEND_RD  = 4'd9,
        SEND_LO  = 4'd10,
        SEND_HI  = 4'd11
    } state_t;

    state_t                    state_r, state_s;
    logic [ADDR_WIDTH-1:0]     addr_r, addr_s;
    logic [2*DATA_WIDTH-1:0]   result_r, result_s;
    logic [ADDR_WIDTH-1:0]     address_r, address_s;
    logic [DATA_WIDTH-1:0]     wr_data_r, wr_data_s;
    logic [ALU_FUN_WIDTH-1:0]  alu_fun_r, alu_fun_s;
    logic [DATA_WIDTH-1:0]     tx_data_r, tx_data_s;
    logic                      wr_en_r, wr_en_s;
    logic                      rd_en_r, rd_en_s;
    logic                      alu_en_r, alu_en_s;
    logic                      clk_en_r, clk_en_s;
    logic                      wr_inc_r, wr_inc_s;

    // State register plus registered copies of every output and latched field
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            result_r  <= '0;
            address_r <= '0;
            wr_data_r <= '0;
            alu_fun_r <= '0;
            tx_data_r <= '0;
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            alu_en_r  <= 1'b0;
            clk_en_r  <= 1'b0;
            wr_inc_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            result_r  <= result_s;
            address_r <= address_s;
            wr_data_r <= wr_data_s;
            alu_fun_r <= alu_fun_s;
            tx_data_r <= tx_data_s;
            wr_en_r   <= wr_en_s;
            rd_en_r   <= rd_en_s;
            alu_en_r  <= alu_en_s;
            clk_en_r  <= clk_en_s;
            wr_inc_r  <= wr_inc_s;
        end
    end

    // Next-state and next-output decode; strobes default low, data fields hold
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        result_s  = result_r;
        address_s = address_r;
        wr_data_s = wr_data_r;
        alu_fun_s = alu_fun_r;
        tx_data_s = tx_data_r;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        alu_en_s  = 1'b0;
        clk_en_s  = 1'b0;
        wr_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_s = WR_ADDR;
                        CMD_RD:     state_s = RD_ADDR;
                        CMD_ALU_OP: state_s = OP_A;
                        CMD_ALU_NP: state_s = FUN;
                        default:    state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s = WR_DATA_ST;
                end else begin
                    state_s = WR_ADDR;
                end
            end
            WR_DATA_ST: begin
                if (RX_D_VLD) begin
                    wr_en_s   = 1'b1;
                    address_s = addr_r;
                    wr_data_s = RX_P_DATA;
                    state_s   = IDLE;
                end else begin
                    state_s = WR_DATA_ST;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_s   = 1'b1;
                    address_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s   = RD_WAIT;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_WAIT: begin
                if (RdData_Valid) begin
                    result_s = {{DATA_WIDTH{1'b0}}, RdData};
                    state_s  = SEND_RD;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            OP_A, OP_B: begin
                if (RX_D_VLD) begin
                    wr_en_s   = 1'b1;
                    address_s = (state_r == OP_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
                    wr_data_s = RX_P_DATA;
                    state_s   = (state_r == OP_A) ? OP_B : FUN;
                end else begin
                    state_s = state_r;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_en_s  = 1'b1;
                    clk_en_s  = 1'b1;
                    alu_fun_s = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    state_s   = ALU_WAIT;
                end else begin
                    state_s = FUN;
                end
            end
            ALU_WAIT: begin
                // Gate stays open until the result is captured
                if (OUT_Valid) begin
                    result_s = ALU_OUT;
                    clk_en_s = 1'b0;
                    state_s  = SEND_LO;
                end else begin
                    clk_en_s = 1'b1;
                    state_s  = ALU_WAIT;
                end
            end
            SEND_RD, SEND_LO, SEND_HI: begin
                if (!FIFO_FULL) begin
                    wr_inc_s  = 1'b1;
                    tx_data_s = (state_r == SEND_HI) ? result_r[2*DATA_WIDTH-1:DATA_WIDTH]
                                                     : result_r[DATA_WIDTH-1:0];
                    state_s   = (state_r == SEND_LO) ? SEND_HI : IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign Address = address_r;
    assign WrEn    = wr_en_r;
    assign RdEn    = rd_en_r;
    assign WrData  = wr_data_r;
    assign ALU_FUN = alu_fun_r;
    assign ALU_EN  = alu_en_r;
    assign CLK_EN  = clk_en_r;
    assign WR_DATA = tx_data_r;
    assign WR_INC  = wr_inc_r;

endmodule
